// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multicycle control path.
// State codes, command constants and mux-select codes live here.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_MEM_ADR = 3'd3,
    S_MEM_RD  = 3'd4,
    S_WB      = 3'd5,
    S_MEM_WR  = 3'd6,
    S_BRANCH  = 3'd7
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_TEQ = 4'b1001;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;

  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;

  typedef struct packed {
    logic       ir_we;
    logic       pc_we;
    logic       pc_src;
    logic       adr_src;
    logic       mem_re;
    logic       mem_we;
    logic       reg_we;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
  } ctrl_t;

  function automatic logic is_test_cmd(
    input logic [3:0] c
  );
    return (c == CMD_TST) || (c == CMD_TEQ) ||
           (c == CMD_CMP) || (c == CMD_CMN);
  endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluation against stored NZCV.
// Odd codes are the inverse of the even code below them.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;
  logic base;

  assign n = flags[3];
  assign z = flags[2];
  assign c = flags[1];
  assign v = flags[0];

  always_comb begin
    base = 1'b0;
    unique case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      3'd7: base = 1'b1;
    endcase
  end

  // 1111 would invert AL into "never"; forced to fail
  assign pass = (cond == COND_NV) ? 1'b0 : (base ^ cond[0]);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: fetch/decode/execute sequencing,
// stored NZCV flags and a retired-instruction counter.
module multicycle_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  op,
  input  logic [3:0]  cmd,
  input  logic        imm_i,
  input  logic        s_bit,
  input  logic        l_bit,
  input  logic [3:0]  cond,
  input  logic [3:0]  alu_flags,
  input  logic        mem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic        adr_src,
  output logic        mem_re,
  output logic        mem_we,
  output logic        reg_we,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [3:0]  flags,
  output logic [2:0]  state,
  output logic [15:0] retired
);

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  flags_q;
  logic [15:0] retired_q;
  logic        cond_pass;
  logic        retire;
  logic        flags_we;
  ctrl_t       ctrl;

  cond_check u_cond (
    .cond  (cond),
    .flags (flags_q),
    .pass  (cond_pass)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!cond_pass) begin
          state_d = S_FETCH;
        end else begin
          unique case (op)
            OP_DP:  state_d = S_EXEC;
            OP_MEM: state_d = S_MEM_ADR;
            OP_BR:  state_d = S_BRANCH;
            OP_NOP: state_d = S_FETCH;
          endcase
        end
      end
      S_EXEC:    state_d = S_FETCH;
      S_MEM_ADR: state_d = l_bit ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready) state_d = S_WB;
      end
      S_WB:      state_d = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready) state_d = S_FETCH;
      end
      S_BRANCH:  state_d = S_FETCH;
    endcase
  end

  // rst_n gates the strobes so an access drops the instant reset hits
  always_comb begin
    ctrl = '0;
    if (rst_n) begin
      unique case (state_q)
        S_FETCH: begin
          ctrl.mem_re    = 1'b1;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.ir_we     = mem_ready;
          ctrl.pc_we     = mem_ready;
        end
        S_DECODE: begin
        end
        S_EXEC: begin
          ctrl.alu_src_b  = imm_i ? SRCB_IMM : SRCB_REG;
          ctrl.result_src = RES_ALU;
          ctrl.reg_we     = ~is_test_cmd(cmd);
        end
        S_MEM_ADR: begin
          ctrl.alu_src_b = imm_i ? SRCB_REG : SRCB_IMM;
        end
        S_MEM_RD: begin
          ctrl.mem_re  = 1'b1;
          ctrl.adr_src = 1'b1;
        end
        S_WB: begin
          ctrl.reg_we     = 1'b1;
          ctrl.result_src = RES_MEM;
        end
        S_MEM_WR: begin
          ctrl.mem_we  = 1'b1;
          ctrl.adr_src = 1'b1;
        end
        S_BRANCH: begin
          ctrl.pc_we  = 1'b1;
          ctrl.pc_src = 1'b1;
        end
      endcase
    end
  end

  assign retire   = (state_q != S_FETCH) && (state_d == S_FETCH);
  assign flags_we = (state_q == S_EXEC) &&
                    (s_bit || is_test_cmd(cmd));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q   <= '0;
      retired_q <= '0;
    end else begin
      if (flags_we) flags_q <= alu_flags;
      if (retire) retired_q <= retired_q + 16'd1;
    end
  end

  assign ir_we      = ctrl.ir_we;
  assign pc_we      = ctrl.pc_we;
  assign pc_src     = ctrl.pc_src;
  assign adr_src    = ctrl.adr_src;
  assign mem_re     = ctrl.mem_re;
  assign mem_we     = ctrl.mem_we;
  assign reg_we     = ctrl.reg_we;
  assign alu_src_b  = ctrl.alu_src_b;
  assign result_src = ctrl.result_src;
  assign flags      = flags_q;
  assign state      = state_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: behavioural model plus
// directed instruction scenarios and randomized traffic.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  op = '0;
  logic [3:0]  cmd = '0;
  logic        imm_i = 1'b0;
  logic        s_bit = 1'b0;
  logic        l_bit = 1'b0;
  logic [3:0]  cond = '0;
  logic [3:0]  alu_flags = '0;
  logic        mem_ready = 1'b0;
  logic        ir_we, pc_we, pc_src, adr_src;
  logic        mem_re, mem_we, reg_we;
  logic [1:0]  alu_src_b, result_src;
  logic [3:0]  flags;
  logic [2:0]  state;
  logic [15:0] retired;

  int n_chk = 0;
  int n_fail = 0;

  // model: phase number, stored flags, retire count
  int          m_ph = 0;
  logic [3:0]  m_fl = '0;
  logic [15:0] m_rt = '0;

  multicycle_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .cmd        (cmd),
    .imm_i      (imm_i),
    .s_bit      (s_bit),
    .l_bit      (l_bit),
    .cond       (cond),
    .alu_flags  (alu_flags),
    .mem_ready  (mem_ready),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .adr_src    (adr_src),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .reg_we     (reg_we),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .flags      (flags),
    .state      (state),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit arm_pass(input logic [3:0] c,
                                  input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit compare_cmd(input logic [3:0] c);
    return (c >= 4'd8) && (c <= 4'd11);
  endfunction

  always @(negedge rst_n) begin
    m_ph = 0;
    m_fl = '0;
    m_rt = '0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      int nx;
      nx = m_ph;
      case (m_ph)
        0: nx = mem_ready ? 1 : 0;
        1: begin
          if (!arm_pass(cond, m_fl)) nx = 0;
          else if (op == 2'd0) nx = 2;
          else if (op == 2'd1) nx = 3;
          else if (op == 2'd2) nx = 7;
          else nx = 0;
        end
        3: nx = l_bit ? 4 : 6;
        4: nx = mem_ready ? 5 : 4;
        6: nx = mem_ready ? 0 : 6;
        default: nx = 0;
      endcase
      if (m_ph == 2 && (s_bit || compare_cmd(cmd)))
        m_fl = alu_flags;
      if (m_ph != 0 && nx == 0) m_rt = m_rt + 16'd1;
      m_ph = nx;
    end
  end

  always @(negedge clk) begin
    logic [6:0] es;
    logic [1:0] eb, er;
    es = '0; eb = 2'd0; er = 2'd0;
    if (rst_n) begin
      case (m_ph)
        0: begin
          es[2] = 1'b1;
          eb = 2'd2;
          if (mem_ready) begin
            es[6] = 1'b1;
            es[5] = 1'b1;
          end
        end
        2: begin
          eb = imm_i ? 2'd1 : 2'd0;
          es[0] = !compare_cmd(cmd);
        end
        3: eb = imm_i ? 2'd0 : 2'd1;
        4: begin es[2] = 1'b1; es[3] = 1'b1; end
        5: begin es[0] = 1'b1; er = 2'd1; end
        6: begin es[1] = 1'b1; es[3] = 1'b1; end
        7: begin es[5] = 1'b1; es[4] = 1'b1; end
        default: ;
      endcase
    end
    chk("strobes", {ir_we, pc_we, pc_src, adr_src,
                    mem_re, mem_we, reg_we}, es);
    chk("alu_src_b", alu_src_b, eb);
    chk("result_src", result_src, er);
    chk("state", state, m_ph[2:0]);
    chk("flags", flags, m_fl);
    chk("retired", retired, m_rt);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ins(input logic [1:0] o, input logic [3:0] cm,
                         input logic im, input logic s,
                         input logic l, input logic [3:0] cd);
    op = o; cmd = cm; imm_i = im; s_bit = s; l_bit = l; cond = cd;
  endtask

  initial begin
    int t, mre;
    bit seen_wb;
    rst_n = 1'b0;
    step();
    step();
    chk("rst_state", state, 16'd0);
    chk("rst_mem_re", mem_re, 16'd0);
    chk("rst_retired", retired, 16'd0);
    chk("rst_flags", flags, 16'd0);
    rst_n = 1'b1;

    // ADD r1,r2,#5
    set_ins(2'b00, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b1110);
    alu_flags = 4'hF;
    mem_ready = 1'b1;
    chk("t1_fetch", state, 16'd0);
    step();
    chk("t1_decode", state, 16'd1);
    chk("t1_dec_regwe", reg_we, 16'd0);
    step();
    chk("t1_exec", state, 16'd2);
    chk("t1_regwe", reg_we, 16'd1);
    chk("t1_srcb", alu_src_b, 16'd1);
    step();
    chk("t1_back", state, 16'd0);
    chk("t1_flags", flags, 16'd0);
    chk("t1_retired", retired, 16'd1);

    // CMP then BEQ
    set_ins(2'b00, 4'b1010, 1'b0, 1'b0, 1'b0, 4'b1110);
    alu_flags = 4'b0100;
    step();
    step();
    chk("t2_exec", state, 16'd2);
    chk("t2_regwe", reg_we, 16'd0);
    step();
    chk("t2_flags", flags, 16'h4);
    set_ins(2'b10, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    alu_flags = 4'b0000;
    step();
    step();
    chk("t2_branch", state, 16'd7);
    chk("t2_pcwe", {pc_we, pc_src}, 16'd3);
    step();
    chk("t2_retired", retired, 16'd3);

    // BNE with Z set: condition fails
    set_ins(2'b10, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0001);
    step();
    chk("t3_pcwe", pc_we, 16'd0);
    step();
    chk("t3_back", state, 16'd0);
    chk("t3_retired", retired, 16'd4);

    // LDR, memory stalls
    set_ins(2'b01, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b1110);
    step();
    mem_ready = 1'b0;
    t = 0; mre = 0; seen_wb = 0;
    while (state != 3'd0 && t < 20) begin
      if (state == 3'd3) chk("t4_srcb", alu_src_b, 16'd1);
      if (state == 3'd4 && mem_re) begin
        mre++;
        if (mre == 3) mem_ready = 1'b1;
      end
      if (state == 3'd5 && reg_we && result_src == 2'd1)
        seen_wb = 1;
      t++;
      step();
    end
    chk("t4_cycles", t[15:0], 16'd6);
    chk("t4_mem_re", mre[15:0], 16'd3);
    chk("t4_wb", {15'd0, seen_wb}, 16'd1);
    chk("t4_retired", retired, 16'd5);

    // STR interrupted by reset
    mem_ready = 1'b1;
    set_ins(2'b01, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b1110);
    step();
    step();
    mem_ready = 1'b0;
    step();
    chk("t5_memwr", {state, mem_we}, {3'd6, 1'b1});
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_memwe", mem_we, 16'd0);
    chk("t5_state", state, 16'd0);
    chk("t5_retired", retired, 16'd0);
    step();
    rst_n = 1'b1;

    // retire counter wrap
    mem_ready = 1'b0;
    force dut.retired_q = 16'hFFFE;
    #1;
    release dut.retired_q;
    m_rt = 16'hFFFE;
    set_ins(2'b11, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b1110);
    mem_ready = 1'b1;
    step();
    step();
    chk("t6_ffff", retired, 16'hFFFF);
    step();
    step();
    chk("t6_wrap", retired, 16'h0000);

    // randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      op = 2'($urandom_range(0, 3));
      cmd = 4'($urandom_range(0, 15));
      imm_i = 1'($urandom_range(0, 1));
      s_bit = 1'($urandom_range(0, 1));
      l_bit = 1'($urandom_range(0, 1));
      cond = 4'($urandom_range(0, 15));
      alu_flags = 4'($urandom_range(0, 15));
      mem_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      step();
    end
    rst_n = 1'b1;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have inputs op (2), cmd (4), imm_i (1), s_bit (1), l_bit (1), cond (4): decoded fields of the current instruction register.
REQ-004 SHALL have input alu_flags (4): NZCV from the ALU, same cycle.
REQ-005 SHALL have input mem_ready (1): memory completes the current access this cycle.
REQ-006 SHALL have outputs ir_we, pc_we, pc_src, adr_src, mem_re, mem_we, reg_we (1 each): datapath strobes. pc_src: 0 = PC+4, 1 = branch target. adr_src: 0 = PC, 1 = ALU address.
REQ-007 SHALL have outputs alu_src_b (2) and result_src (2). alu_src_b: 00 = reg, 01 = imm, 10 = const 4. result_src: 00 = ALU, 01 = mem.
REQ-008 SHALL have outputs flags (4): stored NZCV; state (3): current FSM state; retired (16): retired-instruction count.

Function
REQ-009 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM_ADR=3, MEM_RD=4, WB=5, MEM_WR=6, BRANCH=7.
REQ-010 FETCH SHALL assert mem_re with adr_src=0 and stay in FETCH while mem_ready=0.
REQ-011 In FETCH with mem_ready=1, it SHALL pulse ir_we and pc_we (pc_src=0, alu_src_b=10) for one cycle, then go to DECODE.
REQ-012 DECODE SHALL evaluate cond against stored flags with ARM semantics (0000 EQ … 1110 AL). Code 1111 counts as fail.
REQ-013 If cond fails in DECODE: next state FETCH, no strobes, retired incremented.
REQ-014 If cond passes in DECODE, next state SHALL be: op 00 -> EXEC, 01 -> MEM_ADR, 10 -> BRANCH, 11 -> FETCH. op 11 is treated as a NOP and still retires.
REQ-015 EXEC SHALL set alu_src_b = imm_i ? 01 : 00 and result_src=00.
REQ-016 EXEC SHALL assert reg_we unless cmd is 1000/1001/1010/1011 (TST/TEQ/CMP/CMN).
REQ-017 EXEC SHALL load flags from alu_flags when s_bit=1, or always for cmd 1000–1011. Next state FETCH.
REQ-018 MEM_ADR SHALL set alu_src_b = imm_i ? 00 : 01, matching the offset encoding, then go to MEM_RD if l_bit=1, else MEM_WR.
REQ-019 MEM_RD SHALL assert mem_re with adr_src=1 until mem_ready=1, then go to WB.
REQ-020 WB SHALL assert reg_we with result_src=01 for one cycle, then go to FETCH.
REQ-021 MEM_WR SHALL hold mem_we with adr_src=1 until mem_ready=1, then go to FETCH.
REQ-022 BRANCH SHALL pulse pc_we with pc_src=1 for one cycle, then go to FETCH.
REQ-023 retired SHALL increment by 1 on each transition into FETCH from any state except reset, and wrap 0xFFFF->0x0000.
REQ-024 All strobes SHALL be Moore-decoded from state, except those gated by mem_ready and cond. Strobes not listed for a state are 0.
REQ-025 flags SHALL change only in EXEC and never when a write is suppressed.

Reset
REQ-026 While rst_n=0: state=FETCH, flags=0000, retired=0, all strobes 0. mem_re SHALL be 0 during reset.
REQ-027 Reset asserted mid-access (MEM_RD/MEM_WR) SHALL drop mem_re/mem_we immediately and abandon the access. The instruction does not retire.
REQ-028 After rst_n rises, the first rising edge SHALL begin FETCH.

Structure
REQ-029 State encodings, cmd constants (TST/TEQ/CMP/CMN) and the alu_src_b/result_src codes SHALL live in shared package cpu_pkg.
REQ-030 Condition evaluation SHALL be the sub-module cond_check (cond, flags -> pass).

Verification
REQ-031 Test 1: ADD r1,r2,#5 (op=00, imm_i=1, s_bit=0, cond=1110), mem_ready=1 in fetch. Required: states 0,1,2,0; reg_we=1 only in EXEC; flags unchanged; retired=1.
REQ-032 Test 2: CMP (cmd=1010) with alu_flags=0100. Required: flags=0100 after EXEC, reg_we never 1. A following BEQ (op=10, cond=0000) visits BRANCH with pc_we=1, pc_src=1.
REQ-033 Test 3: BNE (cond=0001) with flags Z=1. Required: DECODE->FETCH, no pc_we with pc_src=1, retired increments.
REQ-034 Test 4: LDR (op=01, l_bit=1) with mem_ready low 3 cycles in MEM_RD. Required: mem_re held 3 cycles, then WB with reg_we=1 and result_src=01; total 6 cycles.
REQ-035 Test 5: STR with rst_n pulsed low in MEM_WR. Required: mem_we=0 asynchronously, state=0, retired=0.
REQ-036 Test 6: preload 0xFFFF retirements. Required: the next retire gives retired=0x0000.
